gray_conv_arbiter: RTL and testbench
====================================

// Module: gray_conv_arbiter
// PURPOSE
//   Shares one binary<->Gray conversion datapath between two requesters.
//   Each requester submits a word and a direction over a valid/ready handshake.
//   A round-robin arbiter picks one request per cycle and registers the
//   converted result into a single-entry output stage with valid/ready
//   handshake, source tag and mode tag. Sits between producer logic and any
//   Gray-coded counter or pointer consumer.
// PARAMETERS
//   WIDTH   4   data width of request and result words (>= 2)
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   req0_valid   in   1      requester 0 has a word
//   req0_ready   out  1      requester 0 word accepted this cycle
//   req0_data    in   WIDTH  requester 0 word
//   req0_mode    in   1      0 = binary->Gray, 1 = Gray->binary
//   req1_valid   in   1      requester 1 has a word
//   req1_ready   out  1      requester 1 word accepted this cycle
//   req1_data    in   WIDTH  requester 1 word
//   req1_mode    in   1      as req0_mode
//   out_valid    out  1      result register holds a result
//   out_ready    in   1      consumer takes result this cycle
//   out_data     out  WIDTH  converted word
//   out_src      out  1      requester index that produced out_data
//   out_mode     out  1      mode used for out_data
// BEHAVIOUR
//   Reset (rst_n low, async): out_valid=0, out_data=0, out_src=0, out_mode=0,
//     priority pointer prio=0 (requester 0 preferred); req*_ready=0 while low.
//   load_en = !out_valid | out_ready (output slot free or draining now).
//   Grant (combinational):
//     - only req0_valid -> grant 0; only req1_valid -> grant 1
//     - both valid -> grant prio; neither -> no grant
//   reqK_ready = load_en & grantK; never both high in one cycle.
//   reqK_ready may depend on the other requester's valid; a requester must
//     not make its own valid depend on its ready.
//   Transfer on edge where reqK_valid & reqK_ready:
//     out_data <= conv(reqK_data, reqK_mode); out_src <= K; out_mode <= reqK_mode;
//     out_valid <= 1; prio <= ~K. Latency: 1 cycle (visible after that edge).
//   prio updates only on a transfer; a lone requester does not starve the
//     other, since prio then points at the idle side.
//   Drain without new load (out_valid & out_ready, no grant): out_valid <= 0;
//     out_data/out_src/out_mode keep last value.
//   Simultaneous drain and load in one cycle: new result replaces old, out_valid stays 1.
//   Stall (out_valid & !out_ready): out_* held stable, both ready=0, prio held.
//   Conversion, purely combinational into the register:
//     mode 0: G = B ^ (B >> 1)
//     mode 1: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i], i = WIDTH-2..0
//   Requester data/mode need only be stable when valid is high.
//   Reset asserted mid-transfer or mid-stall: the pending result is discarded, no
//     replay; first grant after release uses prio=0.
// TESTING
//   1. Reset: rst_n=0 -> out_valid=0, out_data=4'b0000, req0_ready=req1_ready=0.
//   2. req0 only, mode0, data 4'b1011, out_ready=1 -> next cycle out_valid=1,
//      out_data=4'b1110, out_src=0, out_mode=0.
//   3. req1 only, mode1, sweep all 16 Gray codes -> out_data = binary value;
//      round-trip mode0 then mode1 returns original for all 16 words.
//   4. Both valid every cycle, out_ready=1 -> grants 0,1,0,1,...; one ready/cycle;
//      out_src alternates; throughput 1 result/cycle.
//   5. out_valid=1, out_ready=0 for 3 cycles, both valid -> out_data held,
//      both ready=0; out_ready=1 -> drain and new accept same edge.
//   6. rst_n pulsed low during stall with out_data=4'b0110 -> out_valid=0
//      immediately (async); after release, both valid -> req0 granted first.

Source files
------------

// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin front end for a shared binary<->Gray converter.
// One registered result slot with valid/ready, source tag and mode tag.
module gray_conv_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             out_mode
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;
  logic             out_mode_q, out_mode_d;
  logic             prio_q, prio_d;
  logic             load_en;
  logic             gnt0, gnt1;

  function automatic logic [WIDTH-1:0] conv(
    input logic [WIDTH-1:0] w,
    input logic             m
  );
    logic [WIDTH-1:0] r;
    r = w ^ (w >> 1);
    if (m) begin
      r[WIDTH-1] = w[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
        r[i] = r[i+1] ^ w[i];
      end
    end
    return r;
  endfunction

  always_comb begin
    load_en = !out_valid_q | out_ready;
    gnt0 = req0_valid & (!req1_valid | !prio_q);
    gnt1 = req1_valid & (!req0_valid | prio_q);
    // Ready is forced low while reset is held.
    req0_ready = rst_n & load_en & gnt0;
    req1_ready = rst_n & load_en & gnt1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_mode_d  = out_mode_q;
    prio_d      = prio_q;
    unique case (1'b1)
      req0_ready: begin
        out_valid_d = 1'b1;
        out_data_d  = conv(req0_data, req0_mode);
        out_src_d   = 1'b0;
        out_mode_d  = req0_mode;
        prio_d      = 1'b1;
      end
      req1_ready: begin
        out_valid_d = 1'b1;
        out_data_d  = conv(req1_data, req1_mode);
        out_src_d   = 1'b1;
        out_mode_d  = req1_mode;
        prio_d      = 1'b0;
      end
      default: begin
        if (out_valid_q & out_ready) out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      out_mode_q  <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_mode_q  <= out_mode_d;
      prio_q      <= prio_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_mode  = out_mode_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Randomized bench for gray_conv_arbiter against a transaction-level model.
// Each test task drives one scenario and checks ready and output slot inline.
module tb_gray_conv_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_mode;
  logic [W-1:0] req0_data;
  logic         req1_valid, req1_ready, req1_mode;
  logic [W-1:0] req1_data;
  logic         out_valid, out_ready, out_src, out_mode;
  logic [W-1:0] out_data;

  int vectors = 0;
  int errs = 0;

  logic         m_valid, m_src, m_mode, m_prio;
  logic [W-1:0] m_data;
  logic         obs_r0, obs_r1, exp_r0, exp_r1;

  gray_conv_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_data(req0_data), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_data(req1_data), .req1_mode(req1_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .out_mode(out_mode)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Inverse by search: the binary word whose Gray code matches.
  function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
    for (int v = 0; v < (1 << W); v++)
      if (to_gray(W'(v)) == g) return W'(v);
    return '0;
  endfunction

  function automatic logic [W-1:0] ref_conv(input logic [W-1:0] w, input logic m);
    return m ? from_gray(w) : to_gray(w);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_src = 0; m_mode = 0; m_prio = 0;
  endtask

  // Advance one clock: sample readies, predict grant, update model.
  task automatic cycle();
    logic le, g0, g1;
    #1;
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    le = !m_valid || out_ready;
    g0 = req0_valid && (!req1_valid || m_prio == 0);
    g1 = req1_valid && (!req0_valid || m_prio == 1);
    exp_r0 = le && g0;
    exp_r1 = le && g1;
    @(posedge clk);
    #1;
    if (exp_r0) begin
      m_valid = 1; m_data = ref_conv(req0_data, req0_mode);
      m_src = 0; m_mode = req0_mode; m_prio = 1;
    end else if (exp_r1) begin
      m_valid = 1; m_data = ref_conv(req1_data, req1_mode);
      m_src = 1; m_mode = req1_mode; m_prio = 0;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0;
    req0_data = '0; req1_data = '0;
    req0_mode = 0; req1_mode = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    req0_valid = 1; req1_valid = 1;
    out_ready = 1;
    model_reset();
    #2;
    vectors++;
    if ({out_valid, out_data, req0_ready, req1_ready} !== 7'b0) begin
      errs++;
      $display("FAIL reset got v=%b d=%b r0=%b r1=%b want all zero",
               out_valid, out_data, req0_ready, req1_ready);
    end
    #10;
    rst_n = 1;
    idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    idle();
    out_ready = 1;
    req0_valid = 1; req0_data = 4'b1011; req0_mode = 0;
    cycle();
    vectors++;
    if ({obs_r0, obs_r1} !== 2'b10) begin
      errs++;
      $display("FAIL single_ready got %b%b want 10", obs_r0, obs_r1);
    end
    vectors++;
    if ({out_valid, out_data, out_src, out_mode} !== 7'b1_1110_0_0) begin
      errs++;
      $display("FAIL single_out got %b%b%b%b want 1111000",
               out_valid, out_data, out_src, out_mode);
    end
    idle();
    cycle();
    vectors++;
    if ({out_valid, out_data} !== {m_valid, m_data}) begin
      errs++;
      $display("FAIL single_drain got %b %b want %b %b",
               out_valid, out_data, m_valid, m_data);
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] g;
    idle();
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      req1_valid = 1; req1_mode = 1; req1_data = W'(i);
      cycle();
      vectors++;
      if ({out_valid, out_data, out_src, out_mode} !==
          {m_valid, m_data, m_src, m_mode}) begin
        errs++;
        $display("FAIL sweep_g2b[%0d] got %b%b%b%b want %b%b%b%b", i,
                 out_valid, out_data, out_src, out_mode,
                 m_valid, m_data, m_src, m_mode);
      end
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      req0_valid = 1; req0_mode = 0; req0_data = W'(i);
      cycle();
      g = out_data;
      req0_mode = 1; req0_data = g;
      cycle();
      vectors++;
      if ({out_valid, out_data, out_mode} !== {1'b1, W'(i), 1'b1}) begin
        errs++;
        $display("FAIL roundtrip[%0d] got v=%b d=%b m=%b want 1 %b 1",
                 i, out_valid, out_data, out_mode, W'(i));
      end
    end
    idle();
    cycle();
  endtask

  task automatic test_back_to_back();
    logic last_src;
    idle();
    out_ready = 1;
    last_src = m_prio;
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1; req0_data = W'($urandom); req0_mode = 1'($urandom);
      req1_valid = 1; req1_data = W'($urandom); req1_mode = 1'($urandom);
      cycle();
      vectors++;
      if ({obs_r0, obs_r1} !== {exp_r0, exp_r1} || (obs_r0 & obs_r1)) begin
        errs++;
        $display("FAIL rr_ready[%0d] got %b%b want %b%b",
                 i, obs_r0, obs_r1, exp_r0, exp_r1);
      end
      vectors++;
      if ({out_valid, out_data, out_src, out_mode} !==
          {1'b1, m_data, last_src, m_mode}) begin
        errs++;
        $display("FAIL rr_out[%0d] got %b%b%b%b want 1%b%b%b", i,
                 out_valid, out_data, out_src, out_mode,
                 m_data, last_src, m_mode);
      end
      last_src = ~last_src;
    end
    idle();
    cycle();
  endtask

  task automatic test_stall();
    idle();
    out_ready = 1;
    req0_valid = 1; req0_data = W'($urandom); req0_mode = 0;
    cycle();
    out_ready = 0;
    req0_valid = 1; req1_valid = 1;
    req0_data = W'($urandom); req1_data = W'($urandom);
    req1_mode = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if ({obs_r0, obs_r1} !== 2'b00) begin
        errs++;
        $display("FAIL stall_ready[%0d] got %b%b want 00", i, obs_r0, obs_r1);
      end
      vectors++;
      if ({out_valid, out_data, out_src, out_mode} !==
          {m_valid, m_data, m_src, m_mode}) begin
        errs++;
        $display("FAIL stall_hold[%0d] got %b%b%b%b want %b%b%b%b", i,
                 out_valid, out_data, out_src, out_mode,
                 m_valid, m_data, m_src, m_mode);
      end
    end
    out_ready = 1;
    cycle();
    vectors++;
    if ({obs_r0, obs_r1} !== 2'b01) begin
      errs++;
      $display("FAIL stall_release_ready got %b%b want 01", obs_r0, obs_r1);
    end
    vectors++;
    if ({out_valid, out_data, out_src, out_mode} !==
        {1'b1, from_gray(req1_data), 1'b1, 1'b1}) begin
      errs++;
      $display("FAIL stall_release_out got %b%b%b%b want 1%b11",
               out_valid, out_data, out_src, out_mode, from_gray(req1_data));
    end
    idle();
    cycle();
  endtask

  task automatic test_reset_mid();
    idle();
    out_ready = 1;
    req1_valid = 1; req1_data = 4'b0100; req1_mode = 0;
    cycle();
    out_ready = 0;
    req0_valid = 1;
    cycle();
    vectors++;
    if ({out_valid, out_data} !== 5'b1_0110) begin
      errs++;
      $display("FAIL rstmid_setup got %b %b want 1 0110", out_valid, out_data);
    end
    #2;
    rst_n = 0;
    model_reset();
    #1;
    vectors++;
    if ({out_valid, out_data, req0_ready, req1_ready} !== 7'b0) begin
      errs++;
      $display("FAIL rstmid_async got v=%b d=%b r=%b%b want all zero",
               out_valid, out_data, req0_ready, req1_ready);
    end
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    req0_valid = 1; req0_data = W'($urandom); req0_mode = 0;
    req1_valid = 1; req1_data = W'($urandom); req1_mode = 0;
    cycle();
    vectors++;
    if ({obs_r0, obs_r1, out_valid, out_src, out_data} !==
        {2'b10, 1'b1, 1'b0, to_gray(req0_data)}) begin
      errs++;
      $display("FAIL rstmid_first got r=%b%b v=%b s=%b d=%b want 10 1 0 %b",
               obs_r0, obs_r1, out_valid, out_src, out_data, to_gray(req0_data));
    end
    idle();
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_data = W'($urandom); req0_mode = 1'($urandom);
      req1_data = W'($urandom); req1_mode = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      vectors++;
      if ({obs_r0, obs_r1, out_valid, out_data, out_src, out_mode} !==
          {exp_r0, exp_r1, m_valid, m_data, m_src, m_mode}) begin
        errs++;
        $display("FAIL random[%0d] got %b%b %b%b%b%b want %b%b %b%b%b%b", i,
                 obs_r0, obs_r1, out_valid, out_data, out_src, out_mode,
                 exp_r0, exp_r1, m_valid, m_data, m_src, m_mode);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
